scr_base_l3_bk_req_que_mc: RTL and testbench
============================================

Name: scr_base_l3_bk_req_que_mc

Overview:
Multi-channel, parametrised L3 bank request queue.
- Accepts credit-flow-controlled request flits on NUM_CH independent input channels, each buffered in its own DEPTH-entry queue.
- Round-robin arbitrates the channels onto a single issue port toward the bank tag pipeline.
- Retains every issued entry until it clears a fixed-latency rollback window. Rolled-back requests are replayed in order without sender involvement.

Parameters:
NUM_CH, 4, number of input request channels (>=1)
DEPTH, 8, entries per channel queue (power of 2, >=2)
SCRID_W, 8, source id field width
TXNID_W, 12, transaction id field width
OPC_W, 5, opcode field width
SIZE_W, 3, size field width
ADDR_W, 40, address field width
RLBK_LAT, 3, cycles from issue acceptance to rollback decision (>=1)
FLIT_W, SCRID_W+TXNID_W+OPC_W+SIZE_W+ADDR_W, derived; flit packing is {scrid,txnid,opc,size,addr}, addr in LSBs

Ports:
clk  input  1  clock
rst  input  1  reset, asynchronous, active-high
req_in_val_i  input  NUM_CH  per-channel flit valid
req_in_flit_i  input  NUM_CH*FLIT_W  per-channel flit, channel c at [c*FLIT_W +: FLIT_W]
req_in_crdt_o  output  NUM_CH  per-channel one-cycle credit return pulse
req_2tp_val_o  output  1  issue valid
req_2tp_ch_o  output  $clog2(NUM_CH) (min 1)  channel of issued request
req_2tp_scrid_o  output  SCRID_W  issued scrid
req_2tp_txnid_o  output  TXNID_W  issued txnid
req_2tp_opc_o  output  OPC_W  issued opcode
req_2tp_size_o  output  SIZE_W  issued size
req_2tp_addr_o  output  ADDR_W  issued address
req_2tp_ready_i  input  1  tag pipeline accepts issue this cycle
req_2tp_rlbk_i  input  1  rollback of the request accepted RLBK_LAT cycles earlier
err_ovf_o  output  NUM_CH  sticky: flit arrived with channel queue full

Behaviour:
- One clock domain, clk. rst is asynchronous and active-high.
- Reset values: all pointers 0, pipe empty, req_in_crdt_o=0, req_2tp_val_o=0, err_ovf_o=0, RR pointer at channel 0.
- Storage per channel: circular buffer with three pointers, each with a wrap bit.
  - wr_ptr: next write.
  - iss_ptr: next entry to issue.
  - ret_ptr: oldest unretired entry.
- Occupancy is wr_ptr-ret_ptr (0..DEPTH). An entry is issuable when iss_ptr!=wr_ptr.
- Credit init: in the first DEPTH cycles after rst deasserts, req_in_crdt_o is all-ones, giving DEPTH credits per channel.
- Credit return: afterwards, req_in_crdt_o[c] pulses for exactly one cycle per retirement on channel c. At most one retirement occurs per cycle across all channels.
- Input write: req_in_val_i[c] writes the flit at wr_ptr[c] and increments it. The write occurs on every cycle it is asserted; there is no backpressure.
- Overflow: if occupancy==DEPTH when a flit arrives, the flit is dropped, err_ovf_o[c] is set, and it stays set until reset.
- Write-to-issue latency: a flit written in cycle t is issuable at t+1 at the earliest.
- Arbitration: round-robin over channels with an issuable entry, starting from the channel after the last granted one.
  - req_2tp_val_o and the issue fields are combinational from the storage and the grant.
  - The grant holds stable while val=1 and ready=0.
  - The RR pointer advances only on acceptance (val&ready).
  - On acceptance, iss_ptr[ch] increments.
- Rollback pipe: RLBK_LAT stages, each holding {valid, ch}, shifted every cycle. An acceptance enters stage 0. req_2tp_rlbk_i refers to the final stage.
- Final stage valid, rlbk_i=0: ret_ptr[ch] increments (retire) and a credit pulses next cycle.
- Final stage valid, rlbk_i=1:
  - iss_ptr[ch] is set to ret_ptr[ch] (rewind).
  - Every pipe entry with the same ch is invalidated, including an acceptance entering stage 0 in the same cycle.
  - No retirement and no credit occur.
  - Other channels are unaffected.
- rlbk_i while the final stage is invalid: ignored.
- Same-cycle rewind and issue: if channel ch issued in the rewind cycle, that issue is squashed as above. The replayed entry is issuable from the next cycle.
- Simultaneous write, issue and retire on one channel are all legal and independent.
- Full-depth wrap is distinguished by the wrap bits.
- Reset mid-operation: all state clears immediately, pending credits are lost, and credit init restarts after deassertion.

Test Plan:
- Reset, NUM_CH=4, DEPTH=8 -> req_in_crdt_o=4'hF for exactly 8 cycles, then 0. val_o=0 throughout.
- Channel 0 writes txnid 0x001..0x003, ready=1, rlbk=0 -> issued txnids 1,2,3 in cycles t+1..t+3 with ch=0. Credit pulses at t+1+RLBK_LAT+1 onward, one per entry.
- All four channels write one flit in the same cycle, ready=1 -> issue order ch0,ch1,ch2,ch3. Holding ready=0 for 2 cycles keeps ch1's fields stable.
- Channel 2 issues A,B,C back-to-back; rlbk_i=1 at A's decision cycle -> B and C are squashed and no credits are returned. Replay issues A,B,C again in order. After 3 clean decisions, 3 credits are returned.
- DEPTH=8, channel 1 receives 9 flits with ready=0 -> the 9th is dropped, err_ovf_o=4'b0010 and stays set. Occupancy remains 8.
- Assert rst mid-replay with entries outstanding -> outputs go to their reset values asynchronously. After deassertion, credit init delivers 8 credits per channel again.

Source files
------------

// File: rtl/scr_base_l3_bk_req_que_mc_if.sv
// rtl/scr_base_l3_bk_req_que_mc_if.sv - request-in, issue and error signal bundle of the L3 bank request queue
interface scr_base_l3_bk_req_que_mc_if #(
    parameter int NUM_CH  = 4,
    parameter int SCRID_W = 8,
    parameter int TXNID_W = 12,
    parameter int OPC_W   = 5,
    parameter int SIZE_W  = 3,
    parameter int ADDR_W  = 40,
    parameter int FLIT_W  = SCRID_W + TXNID_W + OPC_W + SIZE_W + ADDR_W,
    parameter int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
);
    logic [NUM_CH-1:0]        req_in_val_i;
    logic [NUM_CH*FLIT_W-1:0] req_in_flit_i;
    logic [NUM_CH-1:0]        req_in_crdt_o;
    logic                     req_2tp_val_o;
    logic [CH_W-1:0]          req_2tp_ch_o;
    logic [SCRID_W-1:0]       req_2tp_scrid_o;
    logic [TXNID_W-1:0]       req_2tp_txnid_o;
    logic [OPC_W-1:0]         req_2tp_opc_o;
    logic [SIZE_W-1:0]        req_2tp_size_o;
    logic [ADDR_W-1:0]        req_2tp_addr_o;
    logic                     req_2tp_ready_i;
    logic                     req_2tp_rlbk_i;
    logic [NUM_CH-1:0]        err_ovf_o;

    modport master (
        output req_in_val_i, req_in_flit_i, req_2tp_ready_i, req_2tp_rlbk_i,
        input  req_in_crdt_o, req_2tp_val_o, req_2tp_ch_o, req_2tp_scrid_o,
               req_2tp_txnid_o, req_2tp_opc_o, req_2tp_size_o, req_2tp_addr_o, err_ovf_o
    );

    modport slave (
        input  req_in_val_i, req_in_flit_i, req_2tp_ready_i, req_2tp_rlbk_i,
        output req_in_crdt_o, req_2tp_val_o, req_2tp_ch_o, req_2tp_scrid_o,
               req_2tp_txnid_o, req_2tp_opc_o, req_2tp_size_o, req_2tp_addr_o, err_ovf_o
    );
endinterface

// File: rtl/scr_base_l3_bk_req_que_mc.sv
// rtl/scr_base_l3_bk_req_que_mc.sv - multi-channel L3 bank request queue with round-robin issue and rollback replay
module scr_base_l3_bk_req_que_mc #(
    parameter int NUM_CH   = 4,
    parameter int DEPTH    = 8,
    parameter int SCRID_W  = 8,
    parameter int TXNID_W  = 12,
    parameter int OPC_W    = 5,
    parameter int SIZE_W   = 3,
    parameter int ADDR_W   = 40,
    parameter int RLBK_LAT = 3,
    parameter int FLIT_W   = SCRID_W + TXNID_W + OPC_W + SIZE_W + ADDR_W
) (
    input  logic                        clk,
    input  logic                        rst,
    scr_base_l3_bk_req_que_mc_if.slave  bus
);
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int PW    = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [FLIT_W-1:0]   r_mem     [NUM_CH][DEPTH];
    logic [PW:0]         r_wr_ptr  [NUM_CH];
    logic [PW:0]         r_iss_ptr [NUM_CH];
    logic [PW:0]         r_ret_ptr [NUM_CH];
    logic [CH_W-1:0]     r_rr;
    logic                r_hold;
    logic [CH_W-1:0]     r_hold_ch;
    logic [RLBK_LAT-1:0] r_pv;
    logic [CH_W-1:0]     r_pch     [RLBK_LAT];
    logic [NUM_CH-1:0]   r_crdt;
    logic [NUM_CH-1:0]   r_ovf;
    logic [CNT_W-1:0]    r_init_cnt;

    logic [NUM_CH-1:0]   w_issuable;
    logic [NUM_CH-1:0]   w_full;
    logic                w_val;
    logic [CH_W-1:0]     w_gnt;
    logic                w_acc;
    logic                w_fin_vld;
    logic [CH_W-1:0]     w_fin_ch;
    logic                w_rewind;
    logic                w_retire;
    logic [FLIT_W-1:0]   w_flit;

    function automatic logic [CH_W-1:0] ch_add(input logic [CH_W-1:0] base, input int unsigned off);
        int unsigned s;
        s = 32'(base) + off;
        s = s % 32'(NUM_CH);
        return s[CH_W-1:0];
    endfunction

    always_comb begin
        w_issuable = '0;
        w_full     = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            w_issuable[c] = (r_iss_ptr[c] != r_wr_ptr[c]);
            w_full[c]     = ((r_wr_ptr[c] - r_ret_ptr[c]) == (PW+1)'(DEPTH));
        end
    end

    // A stalled grant is pinned so a newly issuable channel earlier in RR order cannot steal it.
    always_comb begin
        w_val = 1'b0;
        w_gnt = '0;
        if (r_hold && w_issuable[r_hold_ch]) begin
            w_val = 1'b1;
            w_gnt = r_hold_ch;
        end else begin
            for (int k = NUM_CH - 1; k >= 0; k--) begin
                if (w_issuable[ch_add(r_rr, 32'(k))]) begin
                    w_val = 1'b1;
                    w_gnt = ch_add(r_rr, 32'(k));
                end
            end
        end
    end

    assign w_flit    = r_mem[w_gnt][r_iss_ptr[w_gnt][PW-1:0]];
    assign w_acc     = w_val & bus.req_2tp_ready_i;
    assign w_fin_vld = r_pv[RLBK_LAT-1];
    assign w_fin_ch  = r_pch[RLBK_LAT-1];
    assign w_rewind  = w_fin_vld & bus.req_2tp_rlbk_i;
    assign w_retire  = w_fin_vld & ~bus.req_2tp_rlbk_i;

    assign bus.req_2tp_val_o = w_val;
    assign bus.req_2tp_ch_o  = w_gnt;
    assign {bus.req_2tp_scrid_o, bus.req_2tp_txnid_o, bus.req_2tp_opc_o,
            bus.req_2tp_size_o, bus.req_2tp_addr_o} = w_flit;
    assign bus.req_in_crdt_o = r_crdt;
    assign bus.err_ovf_o     = r_ovf;

    always_ff @(posedge clk) begin
        for (int c = 0; c < NUM_CH; c++) begin
            if (bus.req_in_val_i[c] && !w_full[c]) begin
                r_mem[c][r_wr_ptr[c][PW-1:0]] <= bus.req_in_flit_i[c*FLIT_W +: FLIT_W];
            end
        end
    end

    // Rewind wins over a same-cycle issue on the channel: that issue is squashed in the pipe too.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int c = 0; c < NUM_CH; c++) begin
                r_wr_ptr[c]  <= '0;
                r_iss_ptr[c] <= '0;
                r_ret_ptr[c] <= '0;
            end
            r_ovf <= '0;
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (bus.req_in_val_i[c]) begin
                    if (w_full[c]) begin
                        r_ovf[c] <= 1'b1;
                    end else begin
                        r_wr_ptr[c] <= r_wr_ptr[c] + 1'b1;
                    end
                end
                if (w_rewind && (w_fin_ch == CH_W'(c))) begin
                    r_iss_ptr[c] <= r_ret_ptr[c];
                end else if (w_acc && (w_gnt == CH_W'(c))) begin
                    r_iss_ptr[c] <= r_iss_ptr[c] + 1'b1;
                end
                if (w_retire && (w_fin_ch == CH_W'(c))) begin
                    r_ret_ptr[c] <= r_ret_ptr[c] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pv       <= '0;
            for (int s = 0; s < RLBK_LAT; s++) begin
                r_pch[s] <= '0;
            end
            r_rr       <= '0;
            r_hold     <= 1'b0;
            r_hold_ch  <= '0;
            r_crdt     <= '0;
            r_init_cnt <= '0;
        end else begin
            r_pv[0]  <= w_acc && !(w_rewind && (w_fin_ch == w_gnt));
            r_pch[0] <= w_gnt;
            for (int s = 1; s < RLBK_LAT; s++) begin
                r_pv[s]  <= r_pv[s-1] && !(w_rewind && (r_pch[s-1] == w_fin_ch));
                r_pch[s] <= r_pch[s-1];
            end
            if (w_acc) begin
                r_rr <= ch_add(w_gnt, 32'd1);
            end
            r_hold    <= w_val && !bus.req_2tp_ready_i;
            r_hold_ch <= w_gnt;
            if (r_init_cnt != CNT_W'(DEPTH)) begin
                r_init_cnt <= r_init_cnt + 1'b1;
                r_crdt     <= '1;
            end else begin
                for (int c = 0; c < NUM_CH; c++) begin
                    r_crdt[c] <= w_retire && (w_fin_ch == CH_W'(c));
                end
            end
        end
    end
endmodule

// File: tb/tb_scr_base_l3_bk_req_que_mc.sv
// tb/tb_scr_base_l3_bk_req_que_mc.sv - randomized scoreboard bench for the L3 bank request queue
module tb_scr_base_l3_bk_req_que_mc;
    localparam int NUM_CH   = 4;
    localparam int DEPTH    = 8;
    localparam int SCRID_W  = 8;
    localparam int TXNID_W  = 12;
    localparam int OPC_W    = 5;
    localparam int SIZE_W   = 3;
    localparam int ADDR_W   = 40;
    localparam int RLBK_LAT = 3;
    localparam int FLIT_W   = SCRID_W + TXNID_W + OPC_W + SIZE_W + ADDR_W;

    typedef logic [FLIT_W-1:0] flit_t;
    typedef struct {
        int ch;
        int dec;
    } pe_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    scr_base_l3_bk_req_que_mc_if #(
        .NUM_CH(NUM_CH), .SCRID_W(SCRID_W), .TXNID_W(TXNID_W),
        .OPC_W(OPC_W), .SIZE_W(SIZE_W), .ADDR_W(ADDR_W)
    ) bus ();

    scr_base_l3_bk_req_que_mc #(
        .NUM_CH(NUM_CH), .DEPTH(DEPTH), .SCRID_W(SCRID_W), .TXNID_W(TXNID_W),
        .OPC_W(OPC_W), .SIZE_W(SIZE_W), .ADDR_W(ADDR_W), .RLBK_LAT(RLBK_LAT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Flits handed from the driver to the scoreboard, and the reference model state.
    flit_t wr_log [NUM_CH][$];
    flit_t mq     [NUM_CH][$];
    int    m_iss  [NUM_CH];
    pe_t   m_pipe [$];
    int    m_rr, m_hold, m_hold_ch, m_init_left, m_cyc;
    logic [NUM_CH-1:0] m_crdt, m_ovf;
    int    checks = 0;
    int    errors = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d actual=%0h required=%0h", nm, m_cyc, act, exp);
        end
    endtask

    task automatic model_step();
        flit_t f, act;
        int e_val, e_ch, rb_ch, c;
        logic [NUM_CH-1:0] crdt_nx;
        pe_t pe;
        pe_t keep[$];
        if (rst) begin
            chk("rst_val", 128'(bus.req_2tp_val_o), 128'(0));
            chk("rst_crdt", 128'(bus.req_in_crdt_o), 128'(0));
            chk("rst_ovf", 128'(bus.err_ovf_o), 128'(0));
            for (int k = 0; k < NUM_CH; k++) begin
                mq[k].delete();
                m_iss[k] = 0;
            end
            m_pipe.delete();
            m_rr = 0; m_hold = 0; m_hold_ch = 0;
            m_init_left = DEPTH;
            m_crdt = '0; m_ovf = '0;
            return;
        end
        e_val = 0; e_ch = 0;
        if (m_hold != 0 && m_iss[m_hold_ch] < mq[m_hold_ch].size()) begin
            e_val = 1; e_ch = m_hold_ch;
        end else begin
            for (int k = 0; k < NUM_CH; k++) begin
                c = (m_rr + k) % NUM_CH;
                if (e_val == 0 && m_iss[c] < mq[c].size()) begin
                    e_val = 1; e_ch = c;
                end
            end
        end
        chk("issue_val", 128'(bus.req_2tp_val_o), 128'(e_val));
        if (e_val != 0 && bus.req_2tp_val_o) begin
            act = {bus.req_2tp_scrid_o, bus.req_2tp_txnid_o, bus.req_2tp_opc_o,
                   bus.req_2tp_size_o, bus.req_2tp_addr_o};
            chk("issue_ch", 128'(bus.req_2tp_ch_o), 128'(e_ch));
            chk("issue_flit", 128'(act), 128'(mq[e_ch][m_iss[e_ch]]));
        end
        chk("credit", 128'(bus.req_in_crdt_o), 128'(m_crdt));
        chk("ovf", 128'(bus.err_ovf_o), 128'(m_ovf));

        for (int k = 0; k < NUM_CH; k++) begin
            if (bus.req_in_val_i[k]) begin
                if (wr_log[k].size() == 0) begin
                    chk("wr_log_underrun", 128'(0), 128'(1));
                end else begin
                    f = wr_log[k].pop_front();
                    if (mq[k].size() == DEPTH) m_ovf[k] = 1'b1;
                    else mq[k].push_back(f);
                end
            end
        end
        rb_ch = -1;
        crdt_nx = '0;
        if (m_pipe.size() > 0 && m_pipe[0].dec == m_cyc) begin
            pe = m_pipe.pop_front();
            if (bus.req_2tp_rlbk_i) begin
                rb_ch = pe.ch;
                m_iss[pe.ch] = 0;
                foreach (m_pipe[i]) if (m_pipe[i].ch != pe.ch) keep.push_back(m_pipe[i]);
                m_pipe = keep;
            end else begin
                void'(mq[pe.ch].pop_front());
                m_iss[pe.ch]--;
                crdt_nx[pe.ch] = 1'b1;
            end
        end
        if (e_val != 0 && bus.req_2tp_ready_i) begin
            m_rr = (e_ch + 1) % NUM_CH;
            if (e_ch != rb_ch) begin
                m_iss[e_ch]++;
                pe.ch = e_ch;
                pe.dec = m_cyc + RLBK_LAT;
                m_pipe.push_back(pe);
            end
        end
        m_hold = (e_val != 0 && !bus.req_2tp_ready_i) ? 1 : 0;
        m_hold_ch = e_ch;
        if (m_init_left > 0) begin
            m_crdt = '1;
            m_init_left--;
        end else begin
            m_crdt = crdt_nx;
        end
    endtask

    always @(negedge clk) begin
        model_step();
        m_cyc++;
    end

    task automatic idle();
        bus.req_in_val_i    = '0;
        bus.req_in_flit_i   = '0;
        bus.req_2tp_ready_i = 1'b0;
        bus.req_2tp_rlbk_i  = 1'b0;
    endtask

    task automatic run(input int n, input int p_wr, input int p_rdy, input int p_rb, input int only_ch);
        logic [NUM_CH*FLIT_W-1:0] fv;
        logic [NUM_CH-1:0] v;
        logic [95:0] rnd;
        repeat (n) begin
            @(posedge clk);
            #1;
            v = '0;
            for (int c = 0; c < NUM_CH; c++) begin
                rnd = {$urandom(), $urandom(), $urandom()};
                fv[c*FLIT_W +: FLIT_W] = rnd[FLIT_W-1:0];
                if (($urandom_range(0, 99) < p_wr) && (only_ch < 0 || only_ch == c)) begin
                    v[c] = 1'b1;
                    wr_log[c].push_back(rnd[FLIT_W-1:0]);
                end
            end
            bus.req_in_flit_i   = fv;
            bus.req_in_val_i    = v;
            bus.req_2tp_ready_i = ($urandom_range(0, 99) < p_rdy) ? 1'b1 : 1'b0;
            bus.req_2tp_rlbk_i  = ($urandom_range(0, 99) < p_rb) ? 1'b1 : 1'b0;
        end
    endtask

    initial begin
        m_cyc = 0;
        idle();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        run(DEPTH + 2, 0, 50, 0, -1);
        run(300, 20, 70, 0, -1);
        run(30, 0, 100, 0, -1);
        run(12, 100, 0, 0, 1);
        run(30, 0, 100, 0, -1);
        run(400, 25, 70, 25, -1);
        run(40, 30, 80, 15, -1);
        @(posedge clk);
        #1 rst = 1'b1;
        idle();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        run(DEPTH + 2, 0, 60, 0, -1);
        run(250, 20, 80, 15, -1);
        run(40, 0, 100, 0, -1);
        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
